// File: rtl/synth_voice_pkg.sv
// rtl/synth_voice_pkg.sv - shared types, tick defaults and index-width helper for the voice allocator
package synth_voice_pkg;

  typedef enum logic [1:0] {
    V_IDLE    = 2'd0,
    V_HELD    = 2'd1,
    V_RELEASE = 2'd2
  } voice_state_t;

  localparam int DEF_DEBOUNCE_TICKS = 16;
  localparam int DEF_RELEASE_TICKS  = 4800;

  function automatic int key_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/synth_key_debounce.sv
// rtl/synth_key_debounce.sv - one key: 2-flop sync, sample-tick stability counter, press/release pulses
module synth_key_debounce #(
  parameter int DEBOUNCE_TICKS = 16
) (
  input  logic clk,
  input  logic rstn,
  input  logic sample_tick,
  input  logic key_in,
  output logic press_pulse,
  output logic release_pulse
);

  localparam int CW = $clog2(DEBOUNCE_TICKS + 1);

  logic          sync1_q, sync2_q;
  logic          db_q, db_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          press_q, press_d;
  logic          rel_q, rel_d;

  always_comb begin
    cnt_d   = cnt_q;
    db_d    = db_q;
    press_d = 1'b0;
    rel_d   = 1'b0;
    // Any tick where the synced level agrees with the accepted state restarts the count.
    if (sync2_q == db_q) begin
      cnt_d = '0;
    end else if (sample_tick) begin
      if (cnt_q == CW'(DEBOUNCE_TICKS - 1)) begin
        cnt_d   = '0;
        db_d    = ~db_q;
        press_d = ~db_q;
        rel_d   = db_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      db_q    <= 1'b0;
      cnt_q   <= '0;
      press_q <= 1'b0;
      rel_q   <= 1'b0;
    end else begin
      sync1_q <= key_in;
      sync2_q <= sync1_q;
      db_q    <= db_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
      rel_q   <= rel_d;
    end
  end

  assign press_pulse   = press_q;
  assign release_pulse = rel_q;

endmodule

// File: rtl/synth_voice_allocator.sv
// rtl/synth_voice_allocator.sv - debounced key events scheduled one per clock onto NUM_VOICES voices with stealing
module synth_voice_allocator
  import synth_voice_pkg::*;
#(
  parameter int NUM_KEYS       = 4,
  parameter int NUM_VOICES     = 2,
  parameter int DEBOUNCE_TICKS = DEF_DEBOUNCE_TICKS,
  parameter int RELEASE_TICKS  = DEF_RELEASE_TICKS,
  parameter int AGE_W          = 16,
  localparam int KW            = key_w(NUM_KEYS)
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     sample_tick,
  input  logic [NUM_KEYS-1:0]      key_in,
  output logic [NUM_VOICES-1:0]    voice_active,
  output logic [NUM_VOICES-1:0]    voice_gate,
  output logic [NUM_VOICES-1:0]    voice_start,
  output logic [NUM_VOICES*KW-1:0] voice_key,
  output logic [7:0]               steal_count
);

  localparam int VW = key_w(NUM_VOICES);
  localparam int RW = $clog2(RELEASE_TICKS + 1);

  logic [NUM_KEYS-1:0] press_p, rel_p;
  logic [NUM_KEYS-1:0] pend_press_q, pend_press_d, pend_rel_q, pend_rel_d;
  logic [NUM_KEYS-1:0] svc_press, svc_rel;
  logic                ev_valid, ev_is_rel;
  logic [KW-1:0]       ev_key;

  voice_state_t        state_q [NUM_VOICES];
  voice_state_t        state_d [NUM_VOICES];
  logic [KW-1:0]       key_q   [NUM_VOICES];
  logic [KW-1:0]       key_d   [NUM_VOICES];
  logic [AGE_W-1:0]    age_q   [NUM_VOICES];
  logic [AGE_W-1:0]    age_d   [NUM_VOICES];
  logic [RW-1:0]       rcnt_q  [NUM_VOICES];
  logic [RW-1:0]       rcnt_d  [NUM_VOICES];
  logic [NUM_VOICES-1:0] start_q, start_d;
  logic [7:0]          steal_q, steal_d;

  for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
    synth_key_debounce #(
      .DEBOUNCE_TICKS(DEBOUNCE_TICKS)
    ) u_db (
      .clk          (clk),
      .rstn         (rstn),
      .sample_tick  (sample_tick),
      .key_in       (key_in[k]),
      .press_pulse  (press_p[k]),
      .release_pulse(rel_p[k])
    );
  end

  // Releases drain before presses so a stolen-then-released voice never blocks a new press.
  always_comb begin
    svc_rel   = '0;
    svc_press = '0;
    ev_valid  = 1'b0;
    ev_is_rel = 1'b0;
    ev_key    = '0;
    for (int k = 0; k < NUM_KEYS; k++) begin
      if (!ev_valid && pend_rel_q[k]) begin
        ev_valid   = 1'b1;
        ev_is_rel  = 1'b1;
        ev_key     = KW'(k);
        svc_rel[k] = 1'b1;
      end
    end
    for (int k = 0; k < NUM_KEYS; k++) begin
      if (!ev_valid && pend_press_q[k]) begin
        ev_valid     = 1'b1;
        ev_key       = KW'(k);
        svc_press[k] = 1'b1;
      end
    end
    pend_rel_d   = (pend_rel_q & ~svc_rel) | rel_p;
    pend_press_d = (pend_press_q & ~svc_press) | press_p;
  end

  logic          own_hit, idle_hit, rls_hit, held_hit, rel_hit;
  logic [VW-1:0] own_idx, idle_idx, rls_idx, held_idx, rel_idx, tgt_idx;
  logic [RW-1:0] rls_min;
  logic [AGE_W-1:0] held_max;
  logic          do_press, do_rel, is_steal;

  always_comb begin
    own_hit  = 1'b0; own_idx  = '0;
    idle_hit = 1'b0; idle_idx = '0;
    rls_hit  = 1'b0; rls_idx  = '0; rls_min  = '0;
    held_hit = 1'b0; held_idx = '0; held_max = '0;
    rel_hit  = 1'b0; rel_idx  = '0;
    for (int v = 0; v < NUM_VOICES; v++) begin
      if (!own_hit && state_q[v] != V_IDLE && key_q[v] == ev_key) begin
        own_hit = 1'b1;
        own_idx = VW'(v);
      end
      if (!rel_hit && state_q[v] == V_HELD && key_q[v] == ev_key) begin
        rel_hit = 1'b1;
        rel_idx = VW'(v);
      end
      if (!idle_hit && state_q[v] == V_IDLE) begin
        idle_hit = 1'b1;
        idle_idx = VW'(v);
      end
      if (state_q[v] == V_RELEASE && (!rls_hit || rcnt_q[v] < rls_min)) begin
        rls_hit = 1'b1;
        rls_idx = VW'(v);
        rls_min = rcnt_q[v];
      end
      if (state_q[v] == V_HELD && (!held_hit || age_q[v] > held_max)) begin
        held_hit = 1'b1;
        held_idx = VW'(v);
        held_max = age_q[v];
      end
    end
    tgt_idx  = own_hit ? own_idx : idle_hit ? idle_idx : rls_hit ? rls_idx : held_idx;
    is_steal = !own_hit && !idle_hit;
    do_press = ev_valid && !ev_is_rel;
    do_rel   = ev_valid && ev_is_rel && rel_hit;
  end

  // Event updates come last so an allocation overrides a same-cycle tick on that voice.
  always_comb begin
    for (int v = 0; v < NUM_VOICES; v++) begin
      state_d[v] = state_q[v];
      key_d[v]   = key_q[v];
      age_d[v]   = age_q[v];
      rcnt_d[v]  = rcnt_q[v];
      start_d[v] = 1'b0;
      if (sample_tick && state_q[v] != V_IDLE && !(&age_q[v])) begin
        age_d[v] = age_q[v] + AGE_W'(1);
      end
      if (sample_tick && state_q[v] == V_RELEASE) begin
        if (rcnt_q[v] <= RW'(1)) begin
          state_d[v] = V_IDLE;
          rcnt_d[v]  = '0;
        end else begin
          rcnt_d[v] = rcnt_q[v] - RW'(1);
        end
      end
      if (do_rel && rel_idx == VW'(v)) begin
        state_d[v] = V_RELEASE;
        rcnt_d[v]  = RW'(RELEASE_TICKS);
      end
      if (do_press && tgt_idx == VW'(v)) begin
        state_d[v] = V_HELD;
        key_d[v]   = ev_key;
        age_d[v]   = '0;
        start_d[v] = 1'b1;
      end
    end
    steal_d = steal_q;
    if (do_press && is_steal && steal_q != 8'hFF) begin
      steal_d = steal_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pend_press_q <= '0;
      pend_rel_q   <= '0;
      start_q      <= '0;
      steal_q      <= '0;
      for (int v = 0; v < NUM_VOICES; v++) begin
        state_q[v] <= V_IDLE;
        key_q[v]   <= '0;
        age_q[v]   <= '0;
        rcnt_q[v]  <= '0;
      end
    end else begin
      pend_press_q <= pend_press_d;
      pend_rel_q   <= pend_rel_d;
      start_q      <= start_d;
      steal_q      <= steal_d;
      for (int v = 0; v < NUM_VOICES; v++) begin
        state_q[v] <= state_d[v];
        key_q[v]   <= key_d[v];
        age_q[v]   <= age_d[v];
        rcnt_q[v]  <= rcnt_d[v];
      end
    end
  end

  always_comb begin
    voice_active = '0;
    voice_gate   = '0;
    voice_key    = '0;
    for (int v = 0; v < NUM_VOICES; v++) begin
      voice_active[v]          = (state_q[v] != V_IDLE);
      voice_gate[v]            = (state_q[v] == V_HELD);
      voice_key[v*KW +: KW]    = key_q[v];
    end
  end

  assign voice_start = start_q;
  assign steal_count = steal_q;

endmodule

// File: tb/tb_synth_voice_allocator.sv
// tb/tb_synth_voice_allocator.sv - scoreboard bench: expected voice_start events queued, monitor pops and compares
module tb_synth_voice_allocator;

  logic       clk;
  logic       rstn;
  logic       sample_tick;
  logic [3:0] key_in;
  logic [1:0] voice_active, voice_gate, voice_start;
  logic [3:0] voice_key;
  logic [7:0] steal_count;

  synth_voice_allocator #(
    .NUM_KEYS      (4),
    .NUM_VOICES    (2),
    .DEBOUNCE_TICKS(4),
    .RELEASE_TICKS (8),
    .AGE_W         (16)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .sample_tick (sample_tick),
    .key_in      (key_in),
    .voice_active(voice_active),
    .voice_gate  (voice_gate),
    .voice_start (voice_start),
    .voice_key   (voice_key),
    .steal_count (steal_count)
  );

  typedef struct {
    int v;
    int k;
    int s;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  int   ticks_seen = 0;
  int   s0, t0, tk;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    sample_tick = 1'b0;
    forever begin
      repeat (3) @(negedge clk);
      sample_tick = 1'b1;
      @(negedge clk);
      sample_tick = 1'b0;
    end
  end

  always @(posedge clk) if (sample_tick) ticks_seen <= ticks_seen + 1;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, req);
    end
  endtask

  task automatic push(input int v, input int k, input int s);
    exp_t e;
    e.v = v; e.k = k; e.s = s;
    exp_q.push_back(e);
  endtask

  task automatic wait_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      while (!sample_tick) @(posedge clk);
    end
    @(negedge clk);
  endtask

  task automatic wait_start(input string nm, output int t);
    int  n;
    logic found;
    n = 0;
    found = 1'b0;
    while (!found && n < 400) begin
      @(negedge clk);
      n++;
      found = |voice_start;
    end
    check(nm, found, 1'b1);
    t = ticks_seen;
  endtask

  // sel 0 waits for voice_gate[v] low, sel 1 for voice_active[v] low.
  task automatic wait_low(input int sel, input int v, input string nm);
    int  n;
    logic done;
    n = 0;
    done = 1'b0;
    while (!done && n < 400) begin
      @(negedge clk);
      n++;
      done = (sel == 0) ? !voice_gate[v] : !voice_active[v];
    end
    check(nm, done, 1'b1);
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rstn) begin
        for (int v = 0; v < 2; v++) begin
          if (voice_start[v]) begin
            if (exp_q.size() == 0) begin
              check("unexpected_start", 1'b1, 1'b0);
            end else begin
              e = exp_q.pop_front();
              check("start_voice", v, e.v);
              check("start_key", voice_key[v*2 +: 2], e.k);
              check("start_steals", steal_count, e.s);
            end
          end
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    rstn   = 1'b0;
    key_in = 4'b0000;
    repeat (4) @(negedge clk);
    check("rst_active", voice_active, 0);
    check("rst_gate", voice_gate, 0);
    check("rst_start", voice_start, 0);
    check("rst_key", voice_key, 0);
    check("rst_steal", steal_count, 0);
    rstn = 1'b1;

    // 1: basic press, hold, release, 8-tick release tail
    wait_ticks(1);
    key_in[1] = 1'b1;
    s0 = ticks_seen;
    push(0, 1, 0);
    wait_start("t1_start", tk);
    check("t1_latency", tk - s0, 4);
    wait_ticks(20);
    check("t1_gate", voice_gate, 2'b01);
    check("t1_active", voice_active, 2'b01);
    check("t1_key", voice_key, 4'b0001);
    key_in[1] = 1'b0;
    wait_low(0, 0, "t1_gate_fall");
    t0 = ticks_seen;
    check("t1_in_release", voice_active, 2'b01);
    wait_low(1, 0, "t1_idle");
    check("t1_release_ticks", ticks_seen - t0, 8);
    check("t1_key_kept", voice_key, 4'b0001);

    // 2: bounce rejection then a clean press
    wait_ticks(1);
    for (int i = 0; i < 10; i++) begin
      key_in[2] = ~key_in[2];
      wait_ticks(2);
    end
    key_in[2] = 1'b1;
    s0 = ticks_seen;
    push(0, 2, 0);
    wait_start("t2_start", tk);
    check("t2_latency", tk - s0, 4);
    key_in[2] = 1'b0;
    wait_ticks(20);
    check("t2_all_idle", voice_active, 2'b00);

    // 3: three presses debounced together, third steals voice0
    key_in = 4'b1110;
    push(0, 1, 0);
    push(1, 2, 0);
    push(0, 3, 1);
    wait_start("t3_start", tk);
    check("t3_first", voice_start, 2'b01);
    @(negedge clk);
    check("t3_second", voice_start, 2'b10);
    @(negedge clk);
    check("t3_third", voice_start, 2'b01);
    wait_ticks(2);
    check("t3_steals", steal_count, 1);
    check("t3_keys", voice_key, 4'b1011);
    key_in[1] = 1'b0;
    wait_ticks(8);
    check("t3_drop_gate", voice_gate, 2'b11);
    check("t3_drop_keys", voice_key, 4'b1011);

    // 4: RELEASE voice is preferred over an older HELD voice
    key_in[3] = 1'b0;
    wait_low(0, 0, "t4_gate_fall");
    check("t4_v0_release", voice_active, 2'b11);
    wait_ticks(1);
    key_in[0] = 1'b1;
    push(0, 0, 2);
    wait_start("t4_start", tk);
    check("t4_keys", voice_key, 4'b1000);
    check("t4_gate", voice_gate, 2'b11);
    check("t4_steals", steal_count, 2);

    // 5: retrigger of a releasing voice, no steal
    wait_ticks(1);
    key_in[0] = 1'b0;
    wait_low(0, 0, "t5_gate_fall");
    wait_ticks(2);
    check("t5_pre_gate", voice_gate, 2'b10);
    key_in[0] = 1'b1;
    push(0, 0, 2);
    wait_start("t5_start", tk);
    check("t5_gate", voice_gate, 2'b11);
    check("t5_keys", voice_key, 4'b1000);
    check("t5_steals", steal_count, 2);

    // 6: steal oldest HELD, then reset mid-operation
    wait_ticks(1);
    key_in[1] = 1'b1;
    push(1, 1, 3);
    wait_start("t6_start", tk);
    check("t6_keys", voice_key, 4'b0100);
    check("t6_steals", steal_count, 3);
    @(negedge clk);
    #1;
    rstn   = 1'b0;
    key_in = 4'b0010;
    #1;
    check("t6_rst_active", voice_active, 0);
    check("t6_rst_gate", voice_gate, 0);
    check("t6_rst_start", voice_start, 0);
    check("t6_rst_key", voice_key, 0);
    check("t6_rst_steal", steal_count, 0);
    wait_ticks(2);
    rstn = 1'b1;
    s0 = ticks_seen;
    push(0, 1, 0);
    wait_start("t6_restart", tk);
    check("t6_latency", tk - s0, 4);
    wait_ticks(1);
    check("t6_gate", voice_gate, 2'b01);
    check("t6_key", voice_key, 4'b0001);
    check("t6_steals_after", steal_count, 0);

    wait_ticks(4);
    check("queue_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
